// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment scanner.
// Segment patterns are active-low, bit 0 = a .. bit 6 = g.
package seg_scan_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Index n holds the pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {ST_GUARD, ST_SHOW} scan_st_e;

  // Per-slot latched display data.
  typedef struct packed {
    logic [3:0] nib;
    logic       blank;
  } slot_data_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle: BCD sources, selection/blink controls and LED drive.
interface seg_scan_ctrl_if;
  logic [15:0] time_bcd;
  logic [15:0] alarm_bcd;
  logic        sel_alarm;
  logic [3:0]  blink_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        src_alarm;
  logic        frame_done;

  modport master (
    output time_bcd, alarm_bcd, sel_alarm, blink_mask,
    input  an, seg, src_alarm, frame_done
  );

  modport slave (
    input  time_bcd, alarm_bcd, sel_alarm, blink_mask,
    output an, seg, src_alarm, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes blank.
module bcd_to_seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd < 4'd10) seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit scanner with per-slot anode guard, frame-aligned
// source switching and frame-counted digit blinking.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD        = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input logic           clk,
  input logic           rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] GUARD_LAST = SW'(GUARD - 1);
  localparam logic [FW-1:0] FRM_LAST   = FW'(BLINK_FRAMES - 1);

  logic [SW-1:0]   slot_cnt;
  logic [1:0]      dig_idx;
  scan_st_e        state, state_nxt;
  logic [FW-1:0]   frm_cnt;
  logic            blink_ph;
  logic            src_q;
  slot_data_t      slot_q, slot_d;
  logic [3:0][3:0] time_dig, alarm_dig;
  logic [6:0]      dec_seg;
  logic [3:0]      an_q;
  logic [6:0]      seg_q;
  logic            slot_end, frame_end;

  assign time_dig  = bus.time_bcd;
  assign alarm_dig = bus.alarm_bcd;
  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_end && (dig_idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
      state    <= ST_GUARD;
    end else begin
      state <= state_nxt;
      if (slot_end) begin
        slot_cnt <= '0;
        dig_idx  <= dig_idx + 2'd1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_GUARD: if (slot_cnt == GUARD_LAST) state_nxt = ST_SHOW;
      ST_SHOW:  if (slot_end)               state_nxt = ST_GUARD;
      default:                              state_nxt = ST_GUARD;
    endcase
  end

  // Source and blink phase only move on frame boundaries so a frame is coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= 1'b0;
      frm_cnt  <= '0;
      blink_ph <= 1'b0;
    end else if (frame_end) begin
      src_q <= bus.sel_alarm;
      if (frm_cnt == FRM_LAST) begin
        frm_cnt  <= '0;
        blink_ph <= ~blink_ph;
      end else begin
        frm_cnt <= frm_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    slot_d.nib   = src_q ? alarm_dig[dig_idx] : time_dig[dig_idx];
    slot_d.blank = blink_ph & bus.blink_mask[dig_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              slot_q <= '{nib: 4'd0, blank: 1'b1};
    else if (slot_cnt == '0) slot_q <= slot_d;
  end

  bcd_to_seg u_dec (
    .bcd (slot_q.nib),
    .seg (dec_seg)
  );

  // Registered drive: outputs trail the counters by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= ANODE_OFF;
      seg_q <= SEG_BLANK;
    end else if (state == ST_SHOW) begin
      an_q  <= ~(4'b0001 << dig_idx);
      seg_q <= slot_q.blank ? SEG_BLANK : dec_seg;
    end else begin
      an_q  <= ANODE_OFF;
      seg_q <= SEG_BLANK;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.src_alarm  = src_q;
  assign bus.frame_done = frame_end;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl; expected outputs come from a cycle-indexed
// model over recorded input history.
module tb_seg_scan_ctrl;
  localparam int RD = 8;
  localparam int GD = 2;
  localparam int BF = 2;
  localparam int FR = 4 * RD;
  localparam int HN = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(.REFRESH_DIV(RD), .GUARD(GD), .BLINK_FRAMES(BF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] h_time  [HN];
  logic [15:0] h_alarm [HN];
  logic        h_sel   [HN];
  logic [3:0]  h_mask  [HN];
  int k, n_chk, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d got=%0h want=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return ~7'h3F;  1: return ~7'h06;  2: return ~7'h5B;  3: return ~7'h4F;
      4: return ~7'h66;  5: return ~7'h6D;  6: return ~7'h7D;  7: return ~7'h07;
      8: return ~7'h7F;  9: return ~7'h6F;
      default: return 7'h7F;
    endcase
  endfunction

  // Source shown in frame f is whatever sel_alarm was in the last cycle of frame f-1.
  function automatic int src_of(input int f);
    return (f == 0) ? 0 : int'(h_sel[f*FR-1]);
  endfunction

  // Check cycle k (called mid-cycle), then log the inputs the DUT samples at its end.
  task automatic cyc();
    logic [3:0]  an_e;
    logic [6:0]  seg_e;
    logic [15:0] w;
    int j, s, d, f, j0, nib;
    logic bl;
    an_e  = 4'hF;
    seg_e = 7'h7F;
    if (k > 0) begin
      j = k - 1; s = j % RD; d = (j / RD) % 4; f = j / FR;
      if (s >= GD) begin
        j0   = j - s;
        w    = (src_of(f) != 0) ? h_alarm[j0] : h_time[j0];
        nib  = int'((w >> (4 * d)) & 16'hF);
        bl   = (((f / BF) % 2) == 1) && h_mask[j0][d];
        an_e = ~(4'b0001 << d);
        seg_e = bl ? 7'h7F : seg_of(nib);
      end
    end
    chk("an",  bus.an, an_e);
    chk("seg", bus.seg, seg_e);
    chk("src_alarm", bus.src_alarm, src_of(k / FR));
    chk("frame_done", bus.frame_done, (k % FR) == FR - 1);
    h_time[k]  = bus.time_bcd;
    h_alarm[k] = bus.alarm_bcd;
    h_sel[k]   = bus.sel_alarm;
    h_mask[k]  = bus.blink_mask;
    if (k < HN - 1) k++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc();
    end
  endtask

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ($urandom_range(15) == 0) bus.time_bcd  = 16'($urandom);
      if ($urandom_range(15) == 0) bus.alarm_bcd = 16'($urandom);
      if ($urandom_range(19) == 0) bus.sel_alarm = ~bus.sel_alarm;
      if ($urandom_range(31) == 0) bus.blink_mask = 4'($urandom);
      cyc();
    end
  endtask

  initial begin
    int guard;
    n_chk = 0; n_err = 0; k = 0;
    rst_n = 1'b0;
    bus.time_bcd = 16'h1234; bus.alarm_bcd = 16'h0000;
    bus.sel_alarm = 1'b0; bus.blink_mask = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_an", bus.an, 4'hF);
    chk("rst_seg", bus.seg, 7'h7F);
    chk("rst_src", bus.src_alarm, 1'b0);
    chk("rst_fd", bus.frame_done, 1'b0);

    // Release on a negedge: the following posedge ends counter cycle 0.
    rst_n = 1'b1;
    cyc();
    run(3);
    chk("d0_an", bus.an, 4'hE);
    chk("d0_seg", bus.seg, 7'h19);
    run(61);

    // Switch to alarm mid-frame; the frame in progress stays on time digits.
    run(10);
    @(negedge clk);
    bus.alarm_bcd = 16'h0630; bus.sel_alarm = 1'b1;
    cyc();
    run(FR * 2);

    // Non-decimal nibbles blank.
    @(negedge clk);
    bus.sel_alarm = 1'b0; bus.time_bcd = 16'hFA9B;
    cyc();
    run(FR * 2);

    @(negedge clk);
    bus.time_bcd = 16'h1234; bus.blink_mask = 4'b0011;
    cyc();
    run(FR * 6);

    run_rand(800);

    // Async reset during SHOW of digit 2.
    guard = 0;
    while (((k - 1) % FR) != 22 && guard < 2 * FR) begin
      run(1);
      guard++;
    end
    chk("pre_rst_an", bus.an, 4'b1011);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_an", bus.an, 4'hF);
    chk("mid_rst_seg", bus.seg, 7'h7F);
    chk("mid_rst_src", bus.src_alarm, 1'b0);
    chk("mid_rst_fd", bus.frame_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    cyc();
    run_rand(600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles per digit slot (>=4).
REQ-002 SHALL have parameter GUARD, default 1000, meaning anode-off cycles at the start of each slot (1..REFRESH_DIV-2).
REQ-003 SHALL have parameter BLINK_FRAMES, default 125, meaning frames per blink phase (>=1).
REQ-004 SHALL have one clock; reset is asynchronous and active-low: clk  in  1  system clock; rst_n  in  1  async active-low reset.
REQ-005 time_bcd  in  16  clock source, 4 BCD digits, [3:0] = digit 0 (rightmost).
REQ-006 alarm_bcd  in  16  alarm-set source, same layout.
REQ-007 sel_alarm  in  1  level request: 1 = show alarm_bcd, 0 = show time_bcd.
REQ-008 blink_mask  in  4  per-digit blink enable, bit n = digit n.
REQ-009 an  out  4  anode enables, active-low, bit n = digit n.
REQ-010 seg  out  7  cathodes, active-low, seg[0]=a .. seg[6]=g.
REQ-011 src_alarm  out  1  source currently displayed (1 = alarm).
REQ-012 frame_done  out  1  one-cycle pulse at end of digit-3 slot.

Function
REQ-013 SHALL scan digits 0,1,2,3,0... with each slot exactly REFRESH_DIV cycles; slot counter wraps REFRESH_DIV-1 -> 0 and advances digit index mod 4.
REQ-014 SHALL run a two-state FSM per slot: GUARD (an = 4'b1111, seg = 7'h7F) for cycles 0..GUARD-1, then SHOW for cycles GUARD..REFRESH_DIV-1.
REQ-015 In SHOW, an SHALL have exactly one bit low (current digit) and seg SHALL be the decode of the selected nibble.
REQ-016 Decode SHALL map 0-9 to standard 7-segment patterns; nibble values 10-15 SHALL produce blank (7'h7F).
REQ-017 Data path SHALL be registered: seg/an change only on clk edges, one cycle after slot counter/index update; no combinational input-to-output path.
REQ-018 Source arbitration: sel_alarm SHALL be sampled only in the cycle frame_done is asserted; src_alarm updates in the next cycle, so a frame never mixes sources.
REQ-019 Nibble data SHALL be sampled from the selected source at each slot start (slot counter = 0) and held for the slot.
REQ-020 Blink: frame counter counts frame_done pulses, wraps at BLINK_FRAMES-1 and toggles blink phase; when phase = 1 and blink_mask[n] = 1, digit n SHALL show blank during SHOW while its anode is still driven low.
REQ-021 blink_mask changes SHALL take effect at the next slot start; blink phase SHALL not reset on sel_alarm change.
REQ-022 frame_done SHALL assert for exactly one cycle when digit index = 3 and slot counter = REFRESH_DIV-1.
REQ-023 Counter widths SHALL be $clog2 of their parameter; no overflow beyond parameter range.

Reset
REQ-024 On rst_n low, asynchronously: an = 4'b1111, seg = 7'h7F, src_alarm = 0, frame_done = 0, digit index = 0, slot counter = 0, FSM = GUARD, frame counter = 0, blink phase = 0.
REQ-025 After rst_n deasserts, first SHOW of digit 0 SHALL begin at cycle GUARD+1; reset mid-slot SHALL abort the slot with no partial digit.

Structure
REQ-026 Shared package SHALL hold the segment patterns (SEG_BLANK = 7'h7F, digit codes 0-9) and the ANODE_OFF constant.
REQ-027 Decoder SHALL be one sub-module, bcd_to_seg (4-bit in, 7-bit active-low out, purely combinational).

Verification (REFRESH_DIV=8, GUARD=2, BLINK_FRAMES=2)
REQ-028 Reset release, time_bcd=16'h1234, sel_alarm=0 -> slot 0 cycles 0-1 an=1111; cycles 2-7 an=1110, seg=pattern '4'; then digits 3,2,1 in order; frame_done at cycle 31.
REQ-029 sel_alarm 0->1 mid-frame, alarm_bcd=16'h0630 -> remaining slots still show time digits; src_alarm=1 the cycle after frame_done; next frame shows 0,3,6,0.
REQ-030 time_bcd=16'hFA9B -> digits 0 and 2 blank during SHOW with anodes low; digit 1 shows '9'; digit 3 blank.
REQ-031 blink_mask=4'b0011 -> frames 0-1 all digits lit; frames 2-3 digits 0,1 blank; frames 4-5 lit; digits 2,3 never blank.
REQ-032 rst_n pulsed low during SHOW of digit 2 -> an=1111, seg=7'h7F same cycle; restart at digit 0 with GUARD.
REQ-033 Time_bcd changed mid-slot -> displayed seg unchanged until next slot start.
